// File: rtl/rs_pkg.sv
// Shared GF(256) definitions for the RS(204,188) encoder and decoder.
package rs_pkg;

   localparam logic [7:0]  GF_POLY = 8'h1D;
   localparam int unsigned K_DEF   = 188;
   localparam int unsigned N_DEF   = 204;
   localparam int unsigned NPAR    = 16;

   // Generator coefficients; element [i] is the x^i coefficient (x^16 term is implicit 1).
   localparam logic [15:0][7:0] G = {
      8'd59,  8'd13,  8'd104, 8'd189, 8'd68,  8'd209, 8'd30, 8'd8,
      8'd163, 8'd65,  8'd41,  8'd229, 8'd98,  8'd50,  8'd36, 8'd59
   };

   typedef enum logic {
      DATA   = 1'b0,
      PARITY = 1'b1
   } state_t;

   // GF(256) multiply, shift-and-add with reduction by the field polynomial.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
      end
      return acc;
   endfunction

endpackage

// File: rtl/gf256_cmul.sv
// GF(256) multiply by a constant; folds to an XOR network at elaboration.
module gf256_cmul
   import rs_pkg::*;
#(
   parameter logic [7:0] COEF = 8'h01
) (
   input  logic [7:0] a,
   output logic [7:0] p
);

   assign p = gf_mul(a, COEF);

endmodule

// File: rtl/rs_encoder.sv
// RS(204,188) systematic encoder: data passes through, 16 LFSR parity bytes follow.
// Optional RS_ENC_PKT_COUNT_EN adds a 16-bit completed-codeword counter port Pkt_Count.
module rs_encoder #(
   parameter int unsigned K    = rs_pkg::K_DEF,
   parameter int unsigned NPAR = rs_pkg::NPAR
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        In_Valid,
   input  logic        In_Sop,
   input  logic [7:0]  In_Data,
   output logic        In_Ready,
   output logic        Out_Valid,
   output logic        Out_Sop,
   output logic        Out_Eop,
   output logic [7:0]  Out_Data,
   input  logic        Out_Ready,
   output logic        Sop_Err
`ifdef RS_ENC_PKT_COUNT_EN
   ,
   output logic [15:0] Pkt_Count
`endif
);

   import rs_pkg::*;

   localparam int unsigned CW = (K > 1)    ? $clog2(K)    : 1;
   localparam int unsigned PW = (NPAR > 1) ? $clog2(NPAR) : 1;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   pcnt;
   logic [7:0]      par  [NPAR];
   logic [7:0]      prod [NPAR];

   logic            out_adv;
   logic            accept;
   logic            sop_mid;
   logic [7:0]      fb;

   assign out_adv  = !Out_Valid || Out_Ready;
   assign In_Ready = (state == DATA) && out_adv;
   assign accept   = In_Valid && In_Ready;
   // A mid-packet SOP restarts the division, so the old remainder is dropped from feedback.
   assign sop_mid  = In_Sop && (cnt != '0);
   assign fb       = In_Data ^ (sop_mid ? 8'h00 : par[NPAR-1]);

   for (genvar gi = 0; gi < NPAR; gi++) begin : g_mul
      gf256_cmul #(.COEF(G[gi])) u_cmul (
         .a (fb),
         .p (prod[gi])
      );
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= DATA;
         cnt       <= '0;
         pcnt      <= '0;
         for (int i = 0; i < NPAR; i++) par[i] <= 8'h00;
         Out_Valid <= 1'b0;
         Out_Sop   <= 1'b0;
         Out_Eop   <= 1'b0;
         Out_Data  <= 8'h00;
         Sop_Err   <= 1'b0;
      end else begin
         Sop_Err <= 1'b0;
         if (state == DATA) begin
            if (accept) begin
               par[0] <= prod[0];
               for (int i = 1; i < NPAR; i++)
                  par[i] <= (sop_mid ? 8'h00 : par[i-1]) ^ prod[i];
               Out_Data  <= In_Data;
               Out_Valid <= 1'b1;
               Out_Sop   <= (cnt == '0) || sop_mid;
               Out_Eop   <= 1'b0;
               Sop_Err   <= sop_mid;
               if (sop_mid) begin
                  cnt <= CW'(1);
               end else if (cnt == CW'(K - 1)) begin
                  cnt   <= '0;
                  state <= PARITY;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end else if (out_adv) begin
               Out_Valid <= 1'b0;
            end
         end else if (out_adv) begin
            // Shift the remainder out MSB-first; the register empties itself to zero.
            Out_Data <= par[NPAR-1];
            for (int i = 1; i < NPAR; i++) par[i] <= par[i-1];
            par[0]    <= 8'h00;
            Out_Valid <= 1'b1;
            Out_Sop   <= 1'b0;
            Out_Eop   <= (pcnt == PW'(NPAR - 1));
            if (pcnt == PW'(NPAR - 1)) begin
               pcnt  <= '0;
               state <= DATA;
            end else begin
               pcnt <= pcnt + PW'(1);
            end
         end
      end
   end

`ifdef RS_ENC_PKT_COUNT_EN
   always_ff @(posedge Clk) begin
      if (Reset)
         Pkt_Count <= 16'h0000;
      else if (Out_Valid && Out_Eop && Out_Ready)
         Pkt_Count <= Pkt_Count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rs_encoder.sv
// Self-checking bench for rs_encoder against a polynomial long-division RS(204,188) model.
module tb_rs_encoder;

   localparam int K  = 188;
   localparam int NP = 16;
   localparam int N  = 204;

   typedef logic [7:0] msg_t [K];
   typedef logic [7:0] cw_t  [N];

   logic        Clk;
   logic        Reset;
   logic        In_Valid;
   logic        In_Sop;
   logic [7:0]  In_Data;
   logic        In_Ready;
   logic        Out_Valid;
   logic        Out_Sop;
   logic        Out_Eop;
   logic [7:0]  Out_Data;
   logic        Out_Ready;
   logic        Sop_Err;
`ifdef RS_ENC_PKT_COUNT_EN
   logic [15:0] Pkt_Count;
`endif

   rs_encoder dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .In_Valid  (In_Valid),
      .In_Sop    (In_Sop),
      .In_Data   (In_Data),
      .In_Ready  (In_Ready),
      .Out_Valid (Out_Valid),
      .Out_Sop   (Out_Sop),
      .Out_Eop   (Out_Eop),
      .Out_Data  (Out_Data),
      .Out_Ready (Out_Ready),
      .Sop_Err   (Sop_Err)
`ifdef RS_ENC_PKT_COUNT_EN
      ,
      .Pkt_Count (Pkt_Count)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Reference field and generator, built from the field definition.
   logic [7:0] gpoly [NP+1];
   logic [7:0] apow  [NP];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_gen();
      logic [7:0] a;
      for (int j = 0; j <= NP; j++) gpoly[j] = 8'h00;
      gpoly[0] = 8'h01;
      a = 8'h01;
      for (int i = 0; i < NP; i++) begin
         apow[i] = a;
         for (int j = NP; j >= 1; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], a);
         gpoly[0] = gmul(gpoly[0], a);
         a = gmul(a, 8'h02);
      end
   endtask

   // Codeword = message followed by remainder of m(x)*x^16 mod g(x), highest degree first.
   function automatic void encode(input msg_t m, output cw_t cw);
      logic [7:0] c [N];
      logic [7:0] coef;
      for (int j = 0; j < N; j++) c[j] = 8'h00;
      for (int j = 0; j < K; j++) c[N-1-j] = m[j];
      for (int d = N - 1; d >= NP; d--) begin
         coef = c[d];
         if (coef != 8'h00)
            for (int i = 0; i <= NP; i++) c[d-NP+i] = c[d-NP+i] ^ gmul(coef, gpoly[i]);
      end
      for (int j = 0; j < K; j++) cw[j] = m[j];
      for (int p = 0; p < NP; p++) cw[K+p] = c[NP-1-p];
   endfunction

   // Output monitor: every transferred byte with its flags and cycle stamp.
   logic [7:0] oq [$];
   bit         sq [$];
   bit         eq [$];
   int         tq [$];
   int         sop_err_seen = 0;
   int         eop_seen     = 0;
   int         ir_viol      = 0;
   bit         in_parity    = 1'b0;
   bit         rand_rdy     = 1'b0;

   always @(negedge Clk) begin
      if (!Reset && Out_Valid && Out_Ready) begin
         oq.push_back(Out_Data);
         sq.push_back(Out_Sop);
         eq.push_back(Out_Eop);
         tq.push_back(cyc);
         if (Out_Eop) eop_seen++;
      end
      if (!Reset && Sop_Err) sop_err_seen++;
      if (in_parity && !(Out_Valid && Out_Eop) && In_Ready) ir_viol++;
      if (Out_Valid && Out_Eop) in_parity = 1'b0;
   end

   always @(posedge Clk) begin
      #1;
      Out_Ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int first_acc_cyc = 0;
   int last_acc_cyc  = 0;

   task automatic send_pkt(input msg_t m, input int n, input bit sop, input bit gaps);
      bit acc;
      for (int j = 0; j < n; j++) begin
         int  budget = 0;
         bit  done   = 1'b0;
         while (!done) begin
            In_Valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            In_Sop   = sop && (j == 0);
            In_Data  = m[j];
            @(negedge Clk);
            acc = In_Valid && In_Ready;
            @(posedge Clk);
            #1;
            if (acc) begin
               done = 1'b1;
               if (j == 0) first_acc_cyc = cyc;
               last_acc_cyc = cyc;
            end else begin
               budget++;
               if (budget > 2000) begin
                  chk("send_timeout", 32'(budget), 32'd2000);
                  In_Valid = 1'b0;
                  In_Sop   = 1'b0;
                  return;
               end
            end
         end
      end
      In_Valid = 1'b0;
      In_Sop   = 1'b0;
      if (n == K) in_parity = 1'b1;
   endtask

   task automatic wait_for(input string tag, input int n);
      int w = 0;
      while (oq.size() < n && w < 6000) begin
         @(posedge Clk);
         #1;
         w++;
      end
      chk({tag, "_wait"}, 32'(oq.size() >= n), 32'd1);
   endtask

   task automatic check_stream(input string tag, input cw_t exp, input int n, input bit contig);
      int         bad_d = 0;
      int         bad_s = 0;
      int         bad_e = 0;
      int         nz    = 0;
      logic [7:0] s;
      wait_for(tag, n);
      if (oq.size() < n) return;
      for (int j = 0; j < n; j++) begin
         if (oq[j] !== exp[j]) bad_d++;
         if (sq[j] !== (j == 0)) bad_s++;
         if (eq[j] !== (n == N && j == N - 1)) bad_e++;
      end
      chk({tag, "_data_errs"}, 32'(bad_d), 32'd0);
      chk({tag, "_sop_errs"},  32'(bad_s), 32'd0);
      chk({tag, "_eop_errs"},  32'(bad_e), 32'd0);
      if (n == N) begin
         for (int i = 0; i < NP; i++) begin
            s = 8'h00;
            for (int j = 0; j < N; j++) s = gmul(s, apow[i]) ^ oq[j];
            if (s != 8'h00) nz++;
         end
         chk({tag, "_nonzero_synd"}, 32'(nz), 32'd0);
      end
      if (contig) chk({tag, "_span"}, 32'(tq[n-1] - tq[0]), 32'(n - 1));
      repeat (n) begin
         void'(oq.pop_front());
         void'(sq.pop_front());
         void'(eq.pop_front());
         void'(tq.pop_front());
      end
   endtask

   msg_t       m0;
   msg_t       ma;
   msg_t       mb;
   msg_t       rp [3];
   cw_t        ex;
   cw_t        exr [3];
   logic [7:0] exp_par [NP] = '{59, 13, 104, 189, 68, 209, 30, 8, 163, 65, 41, 229, 98, 50, 36, 59};
   int         prev_last;
   int         w;

   initial begin
      build_gen();
      Out_Ready = 1'b1;
      Reset     = 1'b1;
      In_Valid  = 1'b0;
      In_Sop    = 1'b0;
      In_Data   = 8'h00;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      chk("rst_out_valid", 32'(Out_Valid), 32'd0);
      chk("rst_out_sop",   32'(Out_Sop),   32'd0);
      chk("rst_out_eop",   32'(Out_Eop),   32'd0);
      chk("rst_out_data",  32'(Out_Data),  32'd0);
      chk("rst_sop_err",   32'(Sop_Err),   32'd0);
      chk("rst_in_ready",  32'(In_Ready),  32'd1);
      @(posedge Clk);
      #1;

      // All-zero packet
      for (int j = 0; j < K; j++) m0[j] = 8'h00;
      encode(m0, ex);
      send_pkt(m0, K, 1'b1, 1'b0);
      check_stream("zero", ex, N, 1'b1);

      // Single 1 in the last data byte exposes the generator coefficients
      m0[K-1] = 8'h01;
      encode(m0, ex);
      send_pkt(m0, K, 1'b1, 1'b0);
      wait_for("unit_par", N);
      if (oq.size() >= N)
         for (int p = 0; p < NP; p++) chk($sformatf("unit_par%0d", p), 32'(oq[K+p]), 32'(exp_par[p]));
      check_stream("unit", ex, N, 1'b1);

      // Back-to-back random packets at full rate
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < K; j++) rp[k][j] = 8'($urandom);
         encode(rp[k], exr[k]);
      end
      send_pkt(rp[0], K, 1'b1, 1'b0);
      prev_last = last_acc_cyc;
      send_pkt(rp[1], K, 1'b1, 1'b0);
      chk("b2b_accept_gap", 32'(first_acc_cyc - prev_last), 32'd17);
      send_pkt(rp[2], K, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) check_stream($sformatf("b2b%0d", k), exr[k], N, 1'b1);

      // Random backpressure and input gaps
      rand_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < K; j++) rp[k][j] = 8'($urandom);
         encode(rp[k], exr[k]);
         send_pkt(rp[k], K, (k != 1), 1'b1);
      end
      for (int k = 0; k < 3; k++) check_stream($sformatf("bp%0d", k), exr[k], N, 1'b0);
      chk("bp_in_ready_in_parity", 32'(ir_viol), 32'd0);
      rand_rdy = 1'b0;

      // New SOP after 100 bytes restarts the codeword
      for (int j = 0; j < K; j++) begin
         ma[j] = 8'($urandom);
         mb[j] = 8'($urandom);
      end
      send_pkt(ma, 100, 1'b1, 1'b0);
      send_pkt(mb, K, 1'b1, 1'b0);
      encode(ma, ex);
      check_stream("sop_partial", ex, 100, 1'b1);
      encode(mb, ex);
      check_stream("sop_new", ex, N, 1'b1);
      chk("sop_err_pulses", 32'(sop_err_seen), 32'd1);

      // Reset while parity byte 5 is held in the output register
      for (int j = 0; j < K; j++) ma[j] = 8'($urandom);
      encode(ma, ex);
      send_pkt(ma, K, 1'b1, 1'b0);
      w = 0;
      while (oq.size() < K + 5 && w < 2000) begin
         @(posedge Clk);
         #1;
         w++;
      end
      chk("rstmid_reach", 32'(oq.size()), 32'(K + 5));
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset     = 1'b0;
      in_parity = 1'b0;
      @(negedge Clk);
      chk("rstmid_out_valid", 32'(Out_Valid), 32'd0);
      chk("rstmid_in_ready",  32'(In_Ready),  32'd1);
      @(posedge Clk);
      #1;
      check_stream("rstmid_prefix", ex, K + 5, 1'b1);
      for (int j = 0; j < K; j++) mb[j] = 8'($urandom);
      encode(mb, ex);
      send_pkt(mb, K, 1'b1, 1'b0);
      check_stream("rstmid_next", ex, N, 1'b1);

      repeat (5) @(posedge Clk);
      #1;
      chk("codewords_completed", 32'(eop_seen), 32'd10);
      chk("no_extra_bytes", 32'(oq.size()), 32'd0);
`ifdef RS_ENC_PKT_COUNT_EN
      chk("pkt_count", 32'(Pkt_Count), 32'd10);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
